tank_input_sched: RTL and testbench

Per-frame input scheduler between the USB keyboard keycode slots and the two tank instances.
- Shares the 4-slot keycode bus between Player 1 (WASD, Space) and Player 2 (arrows, Enter).
- Resolves multiple held direction keys to one movement keycode per player, in the WASD code space the tanks consume.
- Sequences fire requests through a cooldown FSM and runs the speed-upgrade timers.

---
 rtl/tank_input_pkg.sv | 49 ++++
 rtl/tank_input_player.sv | 128 ++++++++++++
 rtl/tank_input_sched.sv | 41 ++++
 tb/tb_tank_input_sched.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/tank_input_pkg.sv
// Shared keycodes, direction/fire-state types and helpers for the tank input scheduler.
// TANK_SEMI_AUTO_EN adds the WAIT_RELEASE fire state (one shot per key press).
package tank_input_pkg;

  localparam logic [7:0] KC_P1_L    = 8'h04;
  localparam logic [7:0] KC_P1_R    = 8'h07;
  localparam logic [7:0] KC_P1_D    = 8'h16;
  localparam logic [7:0] KC_P1_U    = 8'h1A;
  localparam logic [7:0] KC_P1_FIRE = 8'h2C;

  localparam logic [7:0] KC_P2_L    = 8'h50;
  localparam logic [7:0] KC_P2_R    = 8'h4F;
  localparam logic [7:0] KC_P2_D    = 8'h51;
  localparam logic [7:0] KC_P2_U    = 8'h52;
  localparam logic [7:0] KC_P2_FIRE = 8'h28;

  localparam logic [7:0] OUT_L = 8'h04;
  localparam logic [7:0] OUT_R = 8'h07;
  localparam logic [7:0] OUT_D = 8'h16;
  localparam logic [7:0] OUT_U = 8'h1A;

  typedef enum logic [2:0] {NONE, L, R, D, U} dir_t;

`ifdef TANK_SEMI_AUTO_EN
  typedef enum logic [1:0] {READY, COOLDOWN, WAIT_RELEASE} fire_state_t;
`else
  typedef enum logic [1:0] {READY, COOLDOWN} fire_state_t;
`endif

  function automatic logic [7:0] dir_to_keycode(input dir_t d);
    case (d)
      L:       return OUT_L;
      R:       return OUT_R;
      D:       return OUT_D;
      U:       return OUT_U;
      default: return 8'h00;
    endcase
  endfunction

  // Empty slots (8'h00) never match, so a zero code can't be mistaken for a key.
  function automatic logic has_code(input logic [31:0] kc, input logic [7:0] code);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < 4; i++)
      if (kc[8*i +: 8] == code && code != 8'h00) hit = 1'b1;
    return hit;
  endfunction

endpackage

// File: rtl/tank_input_player.sv
// One player's input path: direction decode/arbitration, fire cooldown FSM, speed timer.
// TANK_SEMI_AUTO_EN makes a held fire key shoot once and then wait for release.
module tank_input_player
  import tank_input_pkg::*;
#(
  parameter int         FIRE_COOLDOWN = 30,
  parameter int         SPEED_FRAMES  = 600,
  parameter logic [7:0] KEY_L         = KC_P1_L,
  parameter logic [7:0] KEY_R         = KC_P1_R,
  parameter logic [7:0] KEY_D         = KC_P1_D,
  parameter logic [7:0] KEY_U         = KC_P1_U,
  parameter logic [7:0] KEY_FIRE      = KC_P1_FIRE
) (
  input  logic        frame_clk,
  input  logic        Reset,
  input  logic [31:0] keycodes,
  input  logic        pickup,
  output logic [7:0]  move_key,
  output logic        fire,
  output logic        speed
);

  localparam logic [7:0] COOL_LOAD = 8'(FIRE_COOLDOWN - 1);
  localparam logic [9:0] SPD_LOAD  = 10'(SPEED_FRAMES);

  logic [3:0]  held;       // {U, D, R, L}
  logic [3:0]  prev_held;
  logic [3:0]  new_dirs;
  logic        fire_held;
  dir_t        sel;
  dir_t        next_dir;
  fire_state_t state;
  logic [7:0]  cool_cnt;
  logic [9:0]  spd_cnt;
  logic [9:0]  spd_next;

  function automatic dir_t pick(input logic [3:0] m);
    if (m[0])      return L;
    else if (m[1]) return R;
    else if (m[2]) return D;
    else if (m[3]) return U;
    else           return NONE;
  endfunction

  function automatic logic is_held(input dir_t d, input logic [3:0] h);
    case (d)
      L:       return h[0];
      R:       return h[1];
      D:       return h[2];
      U:       return h[3];
      default: return 1'b0;
    endcase
  endfunction

  assign held = {has_code(keycodes, KEY_U), has_code(keycodes, KEY_D),
                 has_code(keycodes, KEY_R), has_code(keycodes, KEY_L)};
  assign fire_held = has_code(keycodes, KEY_FIRE);
  assign new_dirs  = held & ~prev_held;

  // A freshly pressed key always wins; otherwise stick with the current choice.
  always_comb begin
    next_dir = NONE;
    if (|new_dirs)              next_dir = pick(new_dirs);
    else if (is_held(sel, held)) next_dir = sel;
    else                         next_dir = pick(held);
  end

  always_comb begin
    spd_next = spd_cnt;
    if (pickup)              spd_next = SPD_LOAD;
    else if (spd_cnt != '0)  spd_next = spd_cnt - 10'd1;
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      prev_held <= '0;
      sel       <= NONE;
      move_key  <= 8'h00;
      spd_cnt   <= '0;
      speed     <= 1'b0;
    end else begin
      prev_held <= held;
      sel       <= next_dir;
      move_key  <= dir_to_keycode(next_dir);
      spd_cnt   <= spd_next;
      speed     <= (spd_next != '0);
    end
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      state    <= READY;
      cool_cnt <= '0;
      fire     <= 1'b0;
    end else begin
      fire <= 1'b0;
      case (state)
        READY: begin
          fire <= fire_held;
          if (fire_held && FIRE_COOLDOWN > 1) begin
            cool_cnt <= COOL_LOAD;
            state    <= COOLDOWN;
          end
`ifdef TANK_SEMI_AUTO_EN
          else if (fire_held) state <= WAIT_RELEASE;
`endif
        end
        COOLDOWN: begin
          if (cool_cnt <= 8'd1) begin
            cool_cnt <= '0;
`ifdef TANK_SEMI_AUTO_EN
            state    <= fire_held ? WAIT_RELEASE : READY;
`else
            state    <= READY;
`endif
          end else begin
            cool_cnt <= cool_cnt - 8'd1;
          end
        end
`ifdef TANK_SEMI_AUTO_EN
        WAIT_RELEASE: if (!fire_held) state <= READY;
`endif
        default: state <= READY;
      endcase
    end
  end

endmodule

// File: rtl/tank_input_sched.sv
// Per-frame input scheduler: shares the keycode bus between the two tanks.
// Build option TANK_SEMI_AUTO_EN selects one-shot fire instead of auto-repeat.
module tank_input_sched
  import tank_input_pkg::*;
#(
  parameter int FIRE_COOLDOWN = 30,
  parameter int SPEED_FRAMES  = 600
) (
  input  logic        frame_clk,
  input  logic        Reset,
  input  logic [31:0] keycodes,
  input  logic        p1_pickup,
  input  logic        p2_pickup,
  output logic [7:0]  p1_move_key,
  output logic [7:0]  p2_move_key,
  output logic        p1_fire,
  output logic        p2_fire,
  output logic        p1_speed,
  output logic        p2_speed
);

  tank_input_player #(
    .FIRE_COOLDOWN(FIRE_COOLDOWN), .SPEED_FRAMES(SPEED_FRAMES),
    .KEY_L(KC_P1_L), .KEY_R(KC_P1_R), .KEY_D(KC_P1_D), .KEY_U(KC_P1_U),
    .KEY_FIRE(KC_P1_FIRE)
  ) u_p1 (
    .frame_clk(frame_clk), .Reset(Reset), .keycodes(keycodes), .pickup(p1_pickup),
    .move_key(p1_move_key), .fire(p1_fire), .speed(p1_speed)
  );

  // Arrow keys are translated to the WASD codes inside the player.
  tank_input_player #(
    .FIRE_COOLDOWN(FIRE_COOLDOWN), .SPEED_FRAMES(SPEED_FRAMES),
    .KEY_L(KC_P2_L), .KEY_R(KC_P2_R), .KEY_D(KC_P2_D), .KEY_U(KC_P2_U),
    .KEY_FIRE(KC_P2_FIRE)
  ) u_p2 (
    .frame_clk(frame_clk), .Reset(Reset), .keycodes(keycodes), .pickup(p2_pickup),
    .move_key(p2_move_key), .fire(p2_fire), .speed(p2_speed)
  );

endmodule

// File: tb/tb_tank_input_sched.sv
// Scoreboard bench for tank_input_sched: stimulus pushes expected outputs, monitor compares.
module tb_tank_input_sched;

  logic        frame_clk = 1'b0;
  logic        Reset     = 1'b1;
  logic [31:0] keycodes  = '0;
  logic        p1_pickup = 1'b0;
  logic        p2_pickup = 1'b0;
  logic [7:0]  p1_move_key, p2_move_key;
  logic        p1_fire, p2_fire, p1_speed, p2_speed;

  int n_checks = 0;
  int n_err    = 0;

  typedef struct {
    logic [7:0] k1, k2;
    logic       f1, f2, s1, s2;
    string      nm;
  } exp_t;

  exp_t exp_q[$];

  tank_input_sched #(.FIRE_COOLDOWN(30), .SPEED_FRAMES(600)) dut (
    .frame_clk(frame_clk), .Reset(Reset), .keycodes(keycodes),
    .p1_pickup(p1_pickup), .p2_pickup(p2_pickup),
    .p1_move_key(p1_move_key), .p2_move_key(p2_move_key),
    .p1_fire(p1_fire), .p2_fire(p2_fire),
    .p1_speed(p1_speed), .p2_speed(p2_speed)
  );

  always #5 frame_clk = ~frame_clk;

  task automatic compare(input exp_t e);
    n_checks++;
    if (p1_move_key !== e.k1 || p2_move_key !== e.k2 || p1_fire !== e.f1 ||
        p2_fire !== e.f2 || p1_speed !== e.s1 || p2_speed !== e.s2) begin
      n_err++;
      $display("FAIL %s: got k1=%h k2=%h f1=%b f2=%b s1=%b s2=%b, expected k1=%h k2=%h f1=%b f2=%b s1=%b s2=%b",
               e.nm, p1_move_key, p2_move_key, p1_fire, p2_fire, p1_speed, p2_speed,
               e.k1, e.k2, e.f1, e.f2, e.s1, e.s2);
    end
  endtask

  // Monitor: each entry pushed at a negedge is due just after the following posedge.
  initial begin
    forever begin
      @(posedge frame_clk);
      #1;
      if (exp_q.size() > 0) compare(exp_q.pop_front());
    end
  end

  task automatic step(input logic rst, input logic [31:0] kc, input logic pk1, input logic pk2,
                      input logic [7:0] k1, input logic [7:0] k2,
                      input logic f1, input logic f2, input logic s1, input logic s2,
                      input string nm);
    exp_t e;
    @(negedge frame_clk);
    Reset     = rst;
    keycodes  = kc;
    p1_pickup = pk1;
    p2_pickup = pk2;
    e.k1 = k1; e.k2 = k2; e.f1 = f1; e.f2 = f2; e.s1 = s1; e.s2 = s2; e.nm = nm;
    exp_q.push_back(e);
  endtask

  function automatic logic fire_pulse(input int k);
`ifdef TANK_SEMI_AUTO_EN
    return (k == 0);
`else
    return (k % 30 == 0);
`endif
  endfunction

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    n_err++;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $fatal(1, "timeout");
  end

  initial begin
    exp_t z;
    // Reset and movement arbitration
    step(1, 32'h0000_1A04, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, "reset_hold");
    step(1, 32'h0000_1A04, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, "reset_hold");
    step(0, 32'h0000_1A04, 0, 0, 8'h04, 8'h00, 0, 0, 0, 0, "l_beats_u");
    for (int i = 0; i < 5; i++)
      step(0, 32'h0000_0004, 0, 0, 8'h04, 8'h00, 0, 0, 0, 0, "hold_l");
    step(0, 32'h0000_0704, 0, 0, 8'h07, 8'h00, 0, 0, 0, 0, "new_r");
    step(0, 32'h0000_0704, 0, 0, 8'h07, 8'h00, 0, 0, 0, 0, "keep_r");
    step(0, 32'h0000_0004, 0, 0, 8'h04, 8'h00, 0, 0, 0, 0, "fallback_l");
    step(0, 32'h0000_0000, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, "idle");
    step(0, 32'h0000_5250, 0, 0, 8'h00, 8'h04, 0, 0, 0, 0, "p2_l_beats_u");
    step(0, 32'h0000_004F, 0, 0, 8'h00, 8'h07, 0, 0, 0, 0, "p2_r_only");
    step(0, 32'h0000_0016, 0, 0, 8'h16, 8'h00, 0, 0, 0, 0, "p1_d");
    step(0, 32'h0000_1A16, 0, 0, 8'h1A, 8'h00, 0, 0, 0, 0, "new_u");
    step(0, 32'h1A1A_1616, 0, 0, 8'h1A, 8'h00, 0, 0, 0, 0, "dup_keep_u");
    step(0, 32'h0000_1633, 0, 0, 8'h16, 8'h00, 0, 0, 0, 0, "unmapped");
    step(0, 32'h5100_0700, 0, 0, 8'h07, 8'h16, 0, 0, 0, 0, "both_players");
    step(0, 32'h0000_0000, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, "idle2");

    // Fire: both keys held 100 frames
    for (int k = 0; k < 100; k++)
      step(0, 32'h0000_282C, 0, 0, 8'h00, 8'h00, fire_pulse(k), fire_pulse(k), 0, 0, "fire_hold");
    for (int k = 0; k < 40; k++)
      step(0, 32'h0000_0000, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, "fire_release");
    step(0, 32'h0000_002C, 0, 0, 8'h00, 8'h00, 1, 0, 0, 0, "refire");
    step(0, 32'h0000_0000, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, "refire_off");

    // Speed: single pickup
    for (int j = 0; j <= 601; j++)
      step(0, 32'h0, (j == 0), 0, 8'h00, 8'h00, 0, 0, (j < 600), 0, "speed_single");
    // Reload before expiry on P1, independent single pickup on P2
    for (int j = 0; j <= 1200; j++)
      step(0, 32'h0, (j == 0 || j == 599), (j == 0), 8'h00, 8'h00, 0, 0,
           (j < 1199), (j < 600), "speed_reload");
    // Pickup on the expiry edge
    for (int j = 0; j <= 1201; j++)
      step(0, 32'h0, (j == 0 || j == 600), 0, 8'h00, 8'h00, 0, 0, (j < 1200), 0, "speed_expiry");

    // Reset mid-cooldown and mid-speed
    step(0, 32'h0000_2C04, 1, 0, 8'h04, 8'h00, 1, 0, 1, 0, "pre_reset_fire");
    for (int k = 1; k < 5; k++)
      step(0, 32'h0000_2C04, 0, 0, 8'h04, 8'h00, 0, 0, 1, 0, "pre_reset_hold");
    @(negedge frame_clk);
    Reset = 1'b1;
    #1;
    z.k1 = 8'h00; z.k2 = 8'h00; z.f1 = 0; z.f2 = 0; z.s1 = 0; z.s2 = 0; z.nm = "async_reset";
    compare(z);
    step(1, 32'h0000_2C04, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, "in_reset");
    step(0, 32'h0000_2C04, 0, 0, 8'h04, 8'h00, 1, 0, 0, 0, "post_reset_fire");
    step(0, 32'h0000_2C04, 0, 0, 8'h04, 8'h00, 0, 0, 0, 0, "post_reset_hold");
    step(0, 32'h0000_0000, 0, 0, 8'h00, 8'h00, 0, 0, 0, 0, "final_idle");

    @(posedge frame_clk);
    #2;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
